// File: rtl/i2s_audio_receiver.sv
// I2S ADC receiver: derives mclk/sck/lrck from a free-running counter and captures 16-bit stereo frames.
// Optional peak-level tracking is compiled in when I2S_RX_PEAK_EN is defined.
module i2s_audio_receiver (
   input  logic        clk,
   input  logic        rst,
   output logic        audio_mclk,
   output logic        audio_lrck,
   output logic        audio_sck,
   input  logic        audio_sdout,
   output logic [15:0] audio_out_left,
   output logic [15:0] audio_out_right,
   output logic        sample_valid,
   input  logic        peak_clr,
   output logic [15:0] peak_left,
   output logic [15:0] peak_right
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_LEFT  = 2'd2;
   localparam logic [1:0] ST_RIGHT = 2'd3;

   logic [9:0]  cnt_reg;
   logic [1:0]  state_reg;
   logic [1:0]  state_next;
   logic [15:0] shift_left_reg;
   logic [15:0] shift_right_reg;
   logic [15:0] out_left_reg;
   logic [15:0] out_right_reg;
   logic        valid_reg;

   logic [4:0]  slot;
   logic        capture;
   logic        frame_done;
   logic [15:0] right_next;
   logic        unused_right_msb;

   assign audio_mclk = cnt_reg[1];
   assign audio_sck  = cnt_reg[3];
   assign audio_lrck = cnt_reg[9];

   // Slot 0 carries the I2S one-bit delay; only slots 1..16 hold sample bits.
   assign slot       = cnt_reg[8:4];
   assign capture    = (cnt_reg[3:0] == 4'd8) && (slot >= 5'd1) && (slot <= 5'd16);
   assign frame_done = (state_reg == ST_RIGHT) && (cnt_reg == 10'd776);
   assign right_next = {shift_right_reg[14:0], audio_sdout};
   assign unused_right_msb = shift_right_reg[15];

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  state_next = ST_SYNC;
         ST_SYNC:  if (cnt_reg == 10'd0)    state_next = ST_LEFT;
         ST_LEFT:  if (cnt_reg == 10'd511)  state_next = ST_RIGHT;
         ST_RIGHT: if (cnt_reg == 10'd1023) state_next = ST_LEFT;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         state_reg <= ST_IDLE;
      end else begin
         cnt_reg   <= cnt_reg + 10'd1;
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_left_reg  <= '0;
         shift_right_reg <= '0;
      end else begin
         if (capture && state_reg == ST_LEFT)
            shift_left_reg <= {shift_left_reg[14:0], audio_sdout};
         if (capture && state_reg == ST_RIGHT)
            shift_right_reg <= right_next;
      end
   end

   // The last right bit is sampled in the same cycle the outputs load, so it is forwarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_left_reg  <= '0;
         out_right_reg <= '0;
         valid_reg     <= 1'b0;
      end else begin
         valid_reg <= frame_done;
         if (frame_done) begin
            out_left_reg  <= shift_left_reg;
            out_right_reg <= right_next;
         end
      end
   end

   assign audio_out_left  = out_left_reg;
   assign audio_out_right = out_right_reg;
   assign sample_valid    = valid_reg;

`ifdef I2S_RX_PEAK_EN
   logic [15:0] peak_left_reg;
   logic [15:0] peak_right_reg;
   logic [15:0] abs_left;
   logic [15:0] abs_right;

   function automatic logic [15:0] abs_sat(input logic [15:0] x);
      if (x == 16'h8000)
         return 16'h7FFF;
      else if (x[15])
         return 16'h0000 - x;
      else
         return x;
   endfunction

   assign abs_left  = abs_sat(out_left_reg);
   assign abs_right = abs_sat(out_right_reg);

   always_ff @(posedge clk) begin
      if (rst || peak_clr) begin
         peak_left_reg  <= '0;
         peak_right_reg <= '0;
      end else if (valid_reg) begin
         if (abs_left > peak_left_reg)
            peak_left_reg <= abs_left;
         if (abs_right > peak_right_reg)
            peak_right_reg <= abs_right;
      end
   end

   assign peak_left  = peak_left_reg;
   assign peak_right = peak_right_reg;
`else
   logic unused_peak_clr;

   assign unused_peak_clr = peak_clr;
   assign peak_left       = '0;
   assign peak_right      = '0;
`endif

endmodule

// File: tb/tb_i2s_audio_receiver.sv
// Directed bench for i2s_audio_receiver: a bench-side frame counter drives I2S data and predicts outputs.
module tb_i2s_audio_receiver;

`ifdef I2S_RX_PEAK_EN
   localparam bit PEAK_ON = 1'b1;
`else
   localparam bit PEAK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        audio_sdout = 1'b0;
   logic        peak_clr = 1'b0;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_sck;
   logic [15:0] audio_out_left;
   logic [15:0] audio_out_right;
   logic        sample_valid;
   logic [15:0] peak_left;
   logic [15:0] peak_right;

   int checks = 0;
   int errors = 0;

   logic [9:0]  tb_cnt = '0;
   bit          armed = 1'b0;
   logic [15:0] left_word = 16'h0000;
   logic [15:0] right_word = 16'h0000;
   logic        filler = 1'b0;

   i2s_audio_receiver dut (
      .clk(clk),
      .rst(rst),
      .audio_mclk(audio_mclk),
      .audio_lrck(audio_lrck),
      .audio_sck(audio_sck),
      .audio_sdout(audio_sdout),
      .audio_out_left(audio_out_left),
      .audio_out_right(audio_out_right),
      .sample_valid(sample_valid),
      .peak_clr(peak_clr),
      .peak_left(peak_left),
      .peak_right(peak_right)
   );

   always #5 clk = ~clk;

   function automatic logic sd_bit(input logic [9:0] c);
      int s;
      logic [15:0] w;
      s = int'(c[8:4]);
      w = c[9] ? right_word : left_word;
      if (s >= 1 && s <= 16)
         return w[16 - s];
      return filler;
   endfunction

   // Advance one clk; afterwards tb_cnt equals the counter value the DUT should hold.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst) begin
         tb_cnt = '0;
         armed  = 1'b0;
      end else begin
         tb_cnt = tb_cnt + 10'd1;
         if (tb_cnt == 10'd0)
            armed = 1'b1;
      end
      audio_sdout = sd_bit(tb_cnt);
   endtask

   task automatic run_to_valid(output bit found, output int n);
      found = 1'b0;
      n = 0;
      while (!found && n < 1100) begin
         step();
         n++;
         if (sample_valid === 1'b1)
            found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks += 6;
      if (audio_out_left !== 16'h0) begin errors++; $display("FAIL reset_left got %h want 0000", audio_out_left); end
      if (audio_out_right !== 16'h0) begin errors++; $display("FAIL reset_right got %h want 0000", audio_out_right); end
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
      if ({audio_mclk, audio_sck, audio_lrck} !== 3'b000) begin
         errors++; $display("FAIL reset_clocks got %b want 000", {audio_mclk, audio_sck, audio_lrck});
      end
      if (peak_left !== 16'h0) begin errors++; $display("FAIL reset_peak_left got %h want 0000", peak_left); end
      if (peak_right !== 16'h0) begin errors++; $display("FAIL reset_peak_right got %h want 0000", peak_right); end
      $display("reset: left=%h right=%h valid=%b", audio_out_left, audio_out_right, sample_valid);
   endtask

   task automatic test_clocks();
      int last_m = -1, last_s = -1, last_l = -1;
      int per_m = 0, per_s = 0, per_l = 0;
      int early = 0;
      logic pm, ps, pl;
      left_word = 16'hA5C3; right_word = 16'h1234; filler = 1'b0;
      rst = 1'b0;
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
      for (int i = 1; i <= 1024 + 700; i++) begin
         step();
         if (audio_mclk && !pm) begin if (last_m >= 0) per_m = i - last_m; last_m = i; end
         if (audio_sck && !ps)  begin if (last_s >= 0) per_s = i - last_s; last_s = i; end
         if (audio_lrck && !pl) begin if (last_l >= 0) per_l = i - last_l; last_l = i; end
         pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
         if (sample_valid !== 1'b0) early++;
      end
      checks += 4;
      if (per_m != 4) begin errors++; $display("FAIL mclk_period got %0d want 4", per_m); end
      if (per_s != 16) begin errors++; $display("FAIL sck_period got %0d want 16", per_s); end
      if (per_l != 1024) begin errors++; $display("FAIL lrck_period got %0d want 1024", per_l); end
      if (early != 0) begin errors++; $display("FAIL early_valid got %0d pulses want 0", early); end
      $display("clocks: mclk=%0d sck=%0d lrck=%0d early=%0d", per_m, per_s, per_l, early);
   endtask

   task automatic test_capture();
      bit found; int n;
      run_to_valid(found, n);
      checks += 6;
      if (!found) begin errors++; $display("FAIL capture_timeout got no pulse want pulse"); end
      if (!(armed && tb_cnt == 10'd777)) begin
         errors++; $display("FAIL capture_position got cnt=%0d armed=%0b want cnt=777 armed=1", tb_cnt, armed);
      end
      if (audio_out_left !== 16'hA5C3) begin errors++; $display("FAIL capture_left got %h want a5c3", audio_out_left); end
      if (audio_out_right !== 16'h1234) begin errors++; $display("FAIL capture_right got %h want 1234", audio_out_right); end
      step();
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", sample_valid); end
      if (audio_out_left !== 16'hA5C3) begin errors++; $display("FAIL hold_after_pulse got %h want a5c3", audio_out_left); end
      $display("capture: left=%h right=%h at cnt=%0d", audio_out_left, audio_out_right, tb_cnt);
   endtask

   task automatic test_filler();
      bit found; int n;
      left_word = 16'h0F0F; right_word = 16'h8001; filler = 1'b1;
      while (tb_cnt != 10'd500) step();
      checks += 4;
      if (audio_out_left !== 16'hA5C3 || audio_out_right !== 16'h1234) begin
         errors++; $display("FAIL hold_mid_frame got %h/%h want a5c3/1234", audio_out_left, audio_out_right);
      end
      run_to_valid(found, n);
      if (!found || tb_cnt != 10'd777) begin
         errors++; $display("FAIL filler_position got found=%0b cnt=%0d want found=1 cnt=777", found, tb_cnt);
      end
      if (audio_out_left !== 16'h0F0F) begin errors++; $display("FAIL filler_left got %h want 0f0f", audio_out_left); end
      if (audio_out_right !== 16'h8001) begin errors++; $display("FAIL filler_right got %h want 8001", audio_out_right); end
      filler = 1'b0;
      $display("filler: left=%h right=%h", audio_out_left, audio_out_right);
   endtask

   task automatic test_mid_reset();
      bit found = 1'b0;
      int n = 0, nonzero = 0;
      left_word = 16'h1111; right_word = 16'h2222;
      while (tb_cnt != 10'd500) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks += 6;
      if (audio_out_left !== 16'h0 || audio_out_right !== 16'h0) begin
         errors++; $display("FAIL midreset_clear got %h/%h want 0000/0000", audio_out_left, audio_out_right);
      end
      while (!found && n < 2000) begin
         step();
         n++;
         if (sample_valid === 1'b1) found = 1'b1;
         else if (audio_out_left !== 16'h0 || audio_out_right !== 16'h0) nonzero++;
      end
      if (n != 1024 + 777) begin errors++; $display("FAIL midreset_latency got %0d want 1801", n); end
      if (!(found && armed && tb_cnt == 10'd777)) begin
         errors++; $display("FAIL midreset_position got found=%0b cnt=%0d want found=1 cnt=777", found, tb_cnt);
      end
      if (nonzero != 0) begin errors++; $display("FAIL midreset_outputs got %0d nonzero cycles want 0", nonzero); end
      if (audio_out_left !== 16'h1111) begin errors++; $display("FAIL midreset_left got %h want 1111", audio_out_left); end
      if (audio_out_right !== 16'h2222) begin errors++; $display("FAIL midreset_right got %h want 2222", audio_out_right); end
      $display("mid_reset: latency=%0d left=%h right=%h", n, audio_out_left, audio_out_right);
   endtask

   task automatic test_back_to_back();
      bit found; int n;
      left_word = 16'h7FFF; right_word = 16'h8000;
      run_to_valid(found, n);
      checks += 4;
      if (!found || n != 1024) begin errors++; $display("FAIL b2b_gap1 got %0d want 1024", n); end
      if (audio_out_left !== 16'h7FFF || audio_out_right !== 16'h8000) begin
         errors++; $display("FAIL b2b_data1 got %h/%h want 7fff/8000", audio_out_left, audio_out_right);
      end
      $display("back_to_back: gap=%0d left=%h right=%h", n, audio_out_left, audio_out_right);
      left_word = 16'h0001; right_word = 16'hFFFF;
      run_to_valid(found, n);
      if (!found || n != 1024) begin errors++; $display("FAIL b2b_gap2 got %0d want 1024", n); end
      if (audio_out_left !== 16'h0001 || audio_out_right !== 16'hFFFF) begin
         errors++; $display("FAIL b2b_data2 got %h/%h want 0001/ffff", audio_out_left, audio_out_right);
      end
      $display("back_to_back: gap=%0d left=%h right=%h", n, audio_out_left, audio_out_right);
   endtask

   task automatic test_peak();
      bit found; int n;
      logic [15:0] exp_l [3] = '{16'd256, 16'd4096, 16'd32767};
      logic [15:0] exp_r [3] = '{16'd5, 16'd32767, 16'd32767};
      logic [15:0] words_l [3] = '{16'h0100, 16'hF000, 16'h8000};
      logic [15:0] words_r [3] = '{16'h0005, 16'h8001, 16'h0003};
      logic [15:0] want_l, want_r;
      step();
      peak_clr = 1'b1;
      step();
      peak_clr = 1'b0;
      checks++;
      if (peak_left !== 16'h0 || peak_right !== 16'h0) begin
         errors++; $display("FAIL peak_clear got %h/%h want 0000/0000", peak_left, peak_right);
      end
      for (int k = 0; k < 3; k++) begin
         left_word = words_l[k]; right_word = words_r[k];
         run_to_valid(found, n);
         step();
         want_l = PEAK_ON ? exp_l[k] : 16'h0;
         want_r = PEAK_ON ? exp_r[k] : 16'h0;
         checks++;
         if (!found || peak_left !== want_l || peak_right !== want_r) begin
            errors++; $display("FAIL peak_update%0d got %h/%h want %h/%h", k, peak_left, peak_right, want_l, want_r);
         end
         $display("peak: sample=%h/%h peak=%h/%h", words_l[k], words_r[k], peak_left, peak_right);
      end
      left_word = 16'h0002; right_word = 16'h0002;
      run_to_valid(found, n);
      peak_clr = 1'b1;
      step();
      peak_clr = 1'b0;
      checks++;
      if (!found || peak_left !== 16'h0 || peak_right !== 16'h0) begin
         errors++; $display("FAIL peak_clr_priority got %h/%h want 0000/0000", peak_left, peak_right);
      end
      $display("peak_clr_priority: peak=%h/%h", peak_left, peak_right);
   endtask

   initial begin
      test_reset();
      test_clocks();
      test_capture();
      test_filler();
      test_mid_reset();
      test_back_to_back();
      test_peak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
